// File: rtl/trivium_stream.sv
// trivium_stream: word-parallel Trivium keystream generator streaming W-bit words over valid/ready.
// Optional build macro TRIVIUM_XOR_EN adds a din port that is XORed into ks_data.
module trivium_stream #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [79:0]  key,
  input  logic [79:0]  iv,
  input  logic [15:0]  len,
`ifdef TRIVIUM_XOR_EN
  input  logic [W-1:0] din,
`endif
  output logic         ks_valid,
  input  logic         ks_ready,
  output logic [W-1:0] ks_data,
  output logic         ks_last,
  output logic         busy,
  output logic         done
);

  if (!(W == 1 || W == 2 || W == 4 || W == 8 || W == 16 || W == 32 || W == 64)) begin : g_bad_w
    $fatal(1, "trivium_stream: illegal W=%0d", W);
  end

  localparam int             INIT_STEPS = 1152 / W;
  localparam logic [10:0]    INIT_LAST  = 11'(INIT_STEPS - 1);

  typedef enum logic [1:0] {IDLE, INIT, STREAM} state_t;

  state_t        state_q, state_d;
  logic [287:0]  s_q;
  logic [287:0]  s_step;
  logic [W-1:0]  z_word;
  logic [288:0]  rnd;
  logic [10:0]   init_cnt_q;
  logic [15:0]   word_cnt_q;
  logic [15:0]   len_q;
  logic          done_q;
  logic          hs;
  logic          last_word;
  logic          accept;

  // One Trivium round: returns {z, next state}.
  function automatic logic [288:0] trivium_round(input logic [287:0] st);
    logic t1, t2, t3, z;
    t1 = st[65] ^ st[92];
    t2 = st[161] ^ st[176];
    t3 = st[242] ^ st[287];
    z  = t1 ^ t2 ^ t3;
    return {z,
            st[286:177], t2 ^ (st[174] & st[175]) ^ st[263],
            st[175:93],  t1 ^ (st[90] & st[91]) ^ st[170],
            st[91:0],    t3 ^ (st[285] & st[286]) ^ st[68]};
  endfunction

  // W rounds unrolled; bit i of the word is the z of round i.
  always_comb begin
    rnd    = '0;
    s_step = s_q;
    z_word = '0;
    for (int i = 0; i < W; i++) begin
      rnd       = trivium_round(s_step);
      z_word[i] = rnd[288];
      s_step    = rnd[287:0];
    end
  end

  assign hs        = ks_valid && ks_ready;
  assign last_word = (word_cnt_q == (len_q - 16'd1));
  assign accept    = start && (len != 16'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = INIT;
      INIT:    if (init_cnt_q == INIT_LAST) state_d = STREAM;
      STREAM:  if (hs && last_word) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      s_q        <= '0;
      init_cnt_q <= '0;
      word_cnt_q <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == STREAM) && hs && last_word;
      case (state_q)
        IDLE: begin
          if (accept) begin
            s_q        <= {3'b111, 112'b0, iv, 13'b0, key};
            init_cnt_q <= '0;
            word_cnt_q <= '0;
            len_q      <= len;
          end
        end
        INIT: begin
          s_q        <= s_step;
          init_cnt_q <= init_cnt_q + 11'd1;
        end
        STREAM: begin
          if (hs) begin
            s_q        <= s_step;
            word_cnt_q <= word_cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are gated to zero outside STREAM so idle/reset values are clean.
  assign ks_valid = (state_q == STREAM);
  assign ks_last  = ks_valid && last_word;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
`ifdef TRIVIUM_XOR_EN
  assign ks_data  = ks_valid ? (z_word ^ din) : '0;
`else
  assign ks_data  = ks_valid ? z_word : '0;
`endif

endmodule

// File: tb/tb_trivium_stream.sv
// Directed bench for trivium_stream: W=64, W=8 and W=1 instances against a bit-serial reference.
module tb_trivium_stream;

  localparam logic [79:0] K1 = 80'h0123456789ABCDEF0123;
  localparam logic [79:0] V1 = 80'hFEDCBA98765432100000;
  localparam logic [79:0] K2 = 80'h0F1E2D3C4B5A69788796;
  localparam logic [79:0] V2 = 80'h112233445566778899AA;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [79:0] key, iv;
  logic        start_a, start_b, start_c;
  logic [15:0] len_a, len_b, len_c;
  logic        rdy_a, rdy_b, rdy_c;
  logic        vld_a, vld_b, vld_c;
  logic [63:0] data_a;
  logic [7:0]  data_b;
  logic [0:0]  data_c;
  logic        last_a, last_b, last_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
`ifdef TRIVIUM_XOR_EN
  logic [63:0] din_a;
  logic [7:0]  din_b;
  logic [0:0]  din_c;
`endif

  int total = 0;
  int bad   = 0;

  trivium_stream #(.W(64)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .key(key), .iv(iv), .len(len_a),
`ifdef TRIVIUM_XOR_EN
    .din(din_a),
`endif
    .ks_valid(vld_a), .ks_ready(rdy_a), .ks_data(data_a), .ks_last(last_a),
    .busy(busy_a), .done(done_a)
  );

  trivium_stream #(.W(8)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .key(key), .iv(iv), .len(len_b),
`ifdef TRIVIUM_XOR_EN
    .din(din_b),
`endif
    .ks_valid(vld_b), .ks_ready(rdy_b), .ks_data(data_b), .ks_last(last_b),
    .busy(busy_b), .done(done_b)
  );

  trivium_stream #(.W(1)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .key(key), .iv(iv), .len(len_c),
`ifdef TRIVIUM_XOR_EN
    .din(din_c),
`endif
    .ks_valid(vld_c), .ks_ready(rdy_c), .ks_data(data_c), .ks_last(last_c),
    .busy(busy_c), .done(done_c)
  );

  // Bit-serial reference using the 1-indexed s1..s288 register of the cipher description.
  function automatic logic [511:0] ref_stream(input logic [79:0] k, input logic [79:0] v);
    logic         st [1:288];
    logic [511:0] out;
    logic         t1, t2, t3;
    out = '0;
    for (int i = 1; i <= 288; i++) st[i] = 1'b0;
    for (int i = 0; i < 80; i++) begin
      st[i + 1]  = k[i];
      st[i + 94] = v[i];
    end
    st[286] = 1'b1; st[287] = 1'b1; st[288] = 1'b1;
    for (int r = 0; r < 1152 + 512; r++) begin
      t1 = st[66] ^ st[93];
      t2 = st[162] ^ st[177];
      t3 = st[243] ^ st[288];
      if (r >= 1152) out[r - 1152] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (st[91] & st[92]) ^ st[171];
      t2 = t2 ^ (st[175] & st[176]) ^ st[264];
      t3 = t3 ^ (st[286] & st[287]) ^ st[69];
      for (int j = 288; j > 1; j--) st[j] = st[j - 1];
      st[1]   = t3;
      st[94]  = t1;
      st[178] = t2;
    end
    return out;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] ref0, ref1, ref2, got;
    int cyc, hs;
    reset = 1'b0; key = '0; iv = '0;
    start_a = 0; start_b = 0; start_c = 0;
    len_a = '0; len_b = '0; len_c = '0;
    rdy_a = 0; rdy_b = 0; rdy_c = 0;
`ifdef TRIVIUM_XOR_EN
    din_a = '0; din_b = '0; din_c = '0;
`endif
    ref0 = ref_stream(80'h0, 80'h0);
    ref1 = ref_stream(K1, V1);
    ref2 = ref_stream(K2, V2);
    repeat (3) tick();

    chk("rst_valid", vld_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_last", last_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    reset = 1'b1;
    tick();

    // start with len=0 is ignored
    start_a = 1; len_a = 16'd0; tick(); start_a = 0;
    chk("len0_busy", busy_a, 0);
    tick();
    chk("len0_busy_later", busy_a, 0);

    // bit order: key=0 iv=0 len=4, inputs scrambled after the start edge
    key = '0; iv = '0; len_a = 16'd4; rdy_a = 1; start_a = 1;
    tick();
    start_a = 0; key = '1; iv = '1; len_a = 16'd0;
    chk("bo_busy", busy_a, 1);
    chk("bo_valid_init", vld_a, 0);
    cyc = 0;
    while (!vld_a && cyc < 2000) begin tick(); cyc++; end
    chk("bo_latency", cyc, 18);
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("bo_data%0d", w), data_a, ref0[64*w +: 64]);
      chk($sformatf("bo_last%0d", w), last_a, (w == 3));
      tick();
    end
    chk("bo_done", done_a, 1);
    chk("bo_valid_off", vld_a, 0);
    chk("bo_busy_off", busy_a, 0);
    tick();
    chk("bo_done_pulse", done_a, 0);

    // backpressure plus ignored starts in INIT and STREAM
    key = K1; iv = V1; len_a = 16'd3; rdy_a = 1; start_a = 1;
    tick();
    start_a = 0;
    repeat (4) tick();
    key = K2; iv = V2; len_a = 16'd7; start_a = 1;
    tick();
    start_a = 0;
    cyc = 5;
    while (!vld_a && cyc < 2000) begin tick(); cyc++; end
    chk("bp_latency", cyc, 18);
    hs = 0;
    chk("bp_data0", data_a, ref1[63:0]);
    chk("bp_last0", last_a, 0);
    hs += int'(vld_a && rdy_a);
    tick();
    rdy_a = 0; start_a = 1; len_a = 16'd9;
    for (int i = 0; i < 5; i++) begin
      chk("bp_stall_data", data_a, ref1[127:64]);
      chk("bp_stall_last", last_a, 0);
      hs += int'(vld_a && rdy_a);
      tick();
      start_a = 0;
    end
    rdy_a = 1;
    chk("bp_data1", data_a, ref1[127:64]);
    hs += int'(vld_a && rdy_a);
    tick();
    chk("bp_data2", data_a, ref1[191:128]);
    chk("bp_last2", last_a, 1);
    hs += int'(vld_a && rdy_a);
    tick();
    chk("bp_handshakes", hs, 3);
    chk("bp_done", done_a, 1);
    tick();
    chk("bp_idle", busy_a, 0);

    // reset in the middle of STREAM, then replay the same session
    key = K2; iv = V2; len_a = 16'd8; rdy_a = 1; start_a = 1;
    tick();
    start_a = 0;
    cyc = 0;
    while (!vld_a && cyc < 2000) begin tick(); cyc++; end
    chk("rs_data0", data_a, ref2[63:0]);
    tick();
    chk("rs_data1", data_a, ref2[127:64]);
    tick();
    #2 reset = 1'b0;
    #1;
    chk("rs_valid", vld_a, 0);
    chk("rs_data", data_a, 0);
    chk("rs_last", last_a, 0);
    chk("rs_busy", busy_a, 0);
    chk("rs_done", done_a, 0);
    tick();
    chk("rs_done_held", done_a, 0);
    reset = 1'b1;
    tick();
    start_a = 1;
    tick();
    start_a = 0;
    cyc = 0;
    while (!vld_a && cyc < 2000) begin tick(); cyc++; end
    chk("rs2_latency", cyc, 18);
    for (int w = 0; w < 8; w++) begin
      chk($sformatf("rs2_data%0d", w), data_a, ref2[64*w +: 64]);
      tick();
    end
    chk("rs2_done", done_a, 1);

    // W=8 instance
    key = K1; iv = V1; len_b = 16'd64; rdy_b = 1; start_b = 1;
    tick();
    start_b = 0;
    chk("w8_busy", busy_b, 1);
    cyc = 0;
    while (!vld_b && cyc < 3000) begin tick(); cyc++; end
    chk("w8_latency", cyc, 144);
    got = '0;
    for (int w = 0; w < 64; w++) begin
      got[8*w +: 8] = data_b;
      if (w >= 62) chk($sformatf("w8_last%0d", w), last_b, (w == 63));
      tick();
    end
    chk("w8_done", done_b, 1);
    for (int c = 0; c < 8; c++) chk($sformatf("w8_chunk%0d", c), got[64*c +: 64], ref1[64*c +: 64]);

    // W=1 instance
    len_c = 16'd512; rdy_c = 1; start_c = 1;
    tick();
    start_c = 0;
    chk("w1_busy", busy_c, 1);
    cyc = 0;
    while (!vld_c && cyc < 3000) begin tick(); cyc++; end
    chk("w1_latency", cyc, 1152);
    got = '0;
    for (int w = 0; w < 512; w++) begin
      got[w] = data_c[0];
      if (w == 511) chk("w1_last", last_c, 1);
      tick();
    end
    chk("w1_done", done_c, 1);
    for (int c = 0; c < 8; c++) chk($sformatf("w1_chunk%0d", c), got[64*c +: 64], ref1[64*c +: 64]);

`ifdef TRIVIUM_XOR_EN
    key = '0; iv = '0; len_a = 16'd2; rdy_a = 1; start_a = 1;
    tick();
    start_a = 0;
    cyc = 0;
    while (!vld_a && cyc < 2000) begin tick(); cyc++; end
    din_a = '1;
    #1;
    chk("xor_ones", data_a, ~ref0[63:0]);
    din_a = '0;
    #1;
    chk("xor_zero_w0", data_a, ref0[63:0]);
    tick();
    chk("xor_zero_w1", data_a, ref0[127:64]);
    tick();
    chk("xor_done", done_a, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trivium_stream.md
# trivium_stream

Parametrised Trivium keystream generator, the word-parallel successor to the team's bit-serial Trivium encryptor. It loads an 80-bit key and IV, runs the 1152-round warm-up at W rounds per clock, then streams `len` keystream words over a valid/ready handshake instead of filling a fixed 4096-bit buffer. It sits between the key/IV configuration logic and the data-path XOR stage or a downstream FIFO.

## Interface
- `W`, default 64: keystream bits produced per clock. Legal values are 1, 2, 4, 8, 16, 32 and 64; any other value is a fatal elaboration error.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a session; sampled only in IDLE.
- `key`  in  80  cipher key, sampled on the `start` edge.
- `iv`  in  80  initialisation vector, sampled on the `start` edge.
- `len`  in  16  number of W-bit words to emit, sampled on the `start` edge.
- `ks_valid`  out  1  `ks_data` holds a valid word.
- `ks_ready`  in  1  consumer accepts the word.
- `ks_data`  out  W  keystream word; bit 0 is the earliest generated bit.
- `ks_last`  out  1  the current word is the final word of the session.
- `busy`  out  1  a session is in progress (INIT or STREAM).
- `done`  out  1  one-cycle pulse after the last word is accepted.

## Operation
- State register s[287:0]. Load value is {3'b111, 112'b0, iv, 13'b0, key}, so key occupies [79:0], iv occupies [172:93] and the ones occupy [287:285].
- One Trivium round, 0-indexed:
  - t1 = s65^s92, t2 = s161^s176, t3 = s242^s287.
  - z = t1^t2^t3.
  - s[92:0] ← {s[91:0], t3^(s285&s286)^s68}.
  - s[176:93] ← {s[175:93], t1^(s90&s91)^s170}.
  - s[287:177] ← {s[286:177], t2^(s174&s175)^s263}.
- A W-round step is W rounds unrolled combinationally. Output bit i is the z of round i.
- FSM states:
  - IDLE: on `start` with `len`≠0, load s, clear the round counter, latch `len`, go to INIT. `start` with `len`=0 is ignored.
  - INIT: advance one W-round step per clock and discard z. After 1152/W steps go to STREAM.
  - STREAM:
    - `ks_valid`=1 and `ks_data` = z-word of the current s. It depends only on registers; there is no input-to-output path except under the macro.
    - On each `ks_valid&&ks_ready` edge: advance s by W rounds and increment the word counter.
    - `ks_last`=1 while word counter = latched `len`−1.
    - On the handshake of the last word: go to IDLE and pulse `done`.
- `start` during INIT or STREAM is ignored. `key`, `iv` and `len` may change freely after the start edge.
- Word counter is 16 bits. `len`=65535 is legal; the counter does not wrap within a session.

## Timing
- Reset values: state IDLE, s=0, counters=0, `ks_valid`=0, `ks_data`=0, `ks_last`=0, `busy`=0, `done`=0.
- `start` sampled at edge E0. `busy`=1 from E0.
- `ks_valid` rises at edge E0+1152/W: 18 cycles for W=64, 1152 for W=1.
- With `ks_ready` held high, one word is emitted per cycle.
- Backpressure: while `ks_valid&&!ks_ready`, s, `ks_data` and `ks_last` hold stable.
- After the last handshake edge: `ks_valid`=0, `busy`=0 and `done`=1 for exactly one cycle.
- A new `start` is accepted in the cycle `done` is high.
- Reset asserted mid-session returns all outputs to their reset values immediately, with no `done` pulse.

## Configuration
- `TRIVIUM_XOR_EN` defined:
  - Adds input port `din` [W-1:0].
  - `ks_data` = z-word ^ `din`, combinational from `din`, giving ciphertext or plaintext directly.
  - `din` is meaningful only when `ks_valid`=1.
- `TRIVIUM_XOR_EN` undefined: no `din` port; `ks_data` is the raw keystream.

## Test plan
- Bit-order check: W=64, key=0, iv=0, len=4, `ks_ready`=1 → `ks_valid` at cycle 18, four words, `ks_last` on word 4, `done` one cycle later. Words match a 1-bit software model packed LSB-first.
- Cross-width check: W=1 and W=8 instances with key=80'h0123456789ABCDEF0123, iv=80'hFEDCBA98765432100000, len=512 and 64 respectively → identical 512-bit streams; `ks_valid` rises at cycle 1152 and cycle 144.
- Backpressure: W=64, len=3, `ks_ready` low for 5 cycles on word 2 → `ks_data` and `ks_last` stable throughout; total of exactly 3 handshakes.
- Ignored requests: `start` with `len`=0 → `busy` stays 0. A second `start` pulse during INIT and during STREAM → no restart; word count remains the original `len`.
- Reset mid-STREAM: assert `reset` after word 2 of len=8 → all outputs 0 immediately, no `done`. A new session afterwards reproduces the first-session stream from word 1.
- XOR macro: with `TRIVIUM_XOR_EN`, `din`=64'hFFFF_FFFF_FFFF_FFFF → `ks_data` is the bitwise inverse of the raw keystream; `din`=0 → `ks_data` equals the raw keystream.
